alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//   Parametrised, 2-stage pipelined successor to the single-cycle datapath ALU.
//   Takes WIDTH-bit operands with an 8-op control code and produces result plus
//   zero/neg/carry/ovf flags. Uses valid/ready handshakes on both sides and
//   keeps a saturating overflow counter.
//   Sits between operand fetch and writeback in the CPU execute path.
// PARAMETERS
//   WIDTH  32  operand/result width in bits (>=4, power of two)
//   CNT_W  8   width of saturating overflow event counter
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous, active-low reset
//   in_valid   in   1        operand beat valid
//   in_ready   out  1        block can accept a beat this cycle
//   A          in   WIDTH    operand A
//   B          in   WIDTH    operand B (low $clog2(WIDTH) bits = shift amount)
//   CTRL       in   3        0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLL,7 SRL
//   out_valid  out  1        result beat valid
//   out_ready  in   1        downstream accepts result this cycle
//   R          out  WIDTH    result
//   zero       out  1        R == 0
//   neg        out  1        R[WIDTH-1]
//   carry      out  1        ADD: carry-out; SUB: borrow (A<B unsigned); else 0
//   ovf        out  1        signed overflow, ADD/SUB only; else 0
//   clr_cnt    in   1        synchronous clear of ovf_cnt
//   ovf_cnt    out  CNT_W    count of delivered results with ovf=1, saturating
// BEHAVIOUR
//   - Reset (reset=0, async): s1_valid=s2_valid=0; out_valid=0, R=0, all flags 0,
//     ovf_cnt=0; in_ready=1 from the first edge after release. In-flight beats dropped.
//   - Handshake: a beat transfers on a rising edge with valid&ready. out_valid must
//     not depend on out_ready. While out_valid&!out_ready, R/flags hold stable.
//   - Stage 1 registers A,B,CTRL. Stage 2 registers computed R and flags.
//   - adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1
//     (combinational path out_ready->in_ready is permitted).
//   - Latency: 2 cycles accept-to-out_valid with no stall. Throughput is 1 beat/cycle.
//     Exactly 2 beats buffer under full backpressure. Order is preserved with no
//     loss or duplication.
//   - Arithmetic is modulo 2^WIDTH.
//   - SUB computes A + ~B + 1.
//   - ovf (ADD) = A,B same sign and R sign differs. ovf (SUB) = A,B signs differ
//     and R sign != A sign.
//   - SLT: R = {0..,A<B signed}.
//   - SLL/SRL: logical shift by B[$clog2(WIDTH)-1:0]; upper B bits ignored.
//   - zero and neg are computed from the final R for every op.
//   - ovf_cnt: +1 on each output handshake whose ovf=1, saturates at 2^CNT_W-1.
//     clr_cnt takes priority over a same-cycle increment (result 0).
//   - Undefined CTRL cannot occur (3-bit fully decoded).
// TESTING
//   - ADD A=0x7FFFFFFF B=1, out_ready=1 -> 2 cycles later R=0x80000000, ovf=1,
//     neg=1, carry=0, zero=0; ovf_cnt=1.
//   - SUB A=5 B=5 -> R=0, zero=1, carry=0. SUB A=3 B=5 -> R=0xFFFFFFFE, carry=1,
//     neg=1, ovf=0.
//   - Backpressure: out_ready=0, issue 3 back-to-back beats -> 2 accepted, then
//     in_ready=0. R is stable on beat 1. Raise out_ready -> beats 1,2,3 emerge
//     in order, one per cycle.
//   - WIDTH=8: SLL A=0x81 B=0x09 -> shift 1, R=0x02. SRL A=0x80 B=7 -> R=0x01.
//     SLT A=0xFF B=0x01 -> R=1.
//   - CNT_W=2: 5 ovf results -> ovf_cnt 1,2,3,3,3. clr_cnt coincident with an
//     ovf handshake -> 0.
//   - Assert reset mid-stream with 2 beats in flight -> out_valid=0 and
//     ovf_cnt=0 immediately. After release, the next beat emerges with latency 2.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready on both sides and a
// saturating counter of delivered overflow results.
module alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       CTRL,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int unsigned ShW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSlt, OpSll, OpSrl
  } op_e;

  // Stage 1: captured operands
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  op_e              op_q, op_d;

  // Stage 2: computed result and flags
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d, ovf_q, ovf_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             adv1, adv2;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res;
  logic             res_c, res_o;

  // Combinational ALU operating on stage-1 contents
  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    diff  = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH + 1)'(1);
    res   = '0;
    res_c = 1'b0;
    res_o = 1'b0;
    unique case (op_q)
      OpAdd: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_o = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpSub: begin
        res   = diff[WIDTH-1:0];
        // No carry out of A + ~B + 1 means A < B unsigned, i.e. a borrow.
        res_c = ~diff[WIDTH];
        res_o = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpAnd: res = a_q & b_q;
      OpOr:  res = a_q | b_q;
      OpXor: res = a_q ^ b_q;
      OpSlt: res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OpSll: res = a_q << b_q[ShW-1:0];
      OpSrl: res = a_q >> b_q[ShW-1:0];
      default: res = '0;
    endcase
  end

  // Handshake and pipeline next-state
  always_comb begin
    adv2       = ~s2_valid_q | out_ready;
    adv1       = ~s1_valid_q | adv2;

    s1_valid_d = adv1 ? in_valid : s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    if (adv1 && in_valid) begin
      a_d  = A;
      b_d  = B;
      op_d = op_e'(CTRL);
    end

    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    r_d        = r_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    // Result registers only move when a real beat advances, so a stalled
    // output holds steady.
    if (adv2 && s1_valid_q) begin
      r_d     = res;
      zero_d  = (res == '0);
      neg_d   = res[WIDTH-1];
      carry_d = res_c;
      ovf_d   = res_o;
    end

    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (s2_valid_q && out_ready && ovf_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OpAdd;
      s2_valid_q <= 1'b0;
      r_q        <= '0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      s2_valid_q <= s2_valid_d;
      r_q        <= r_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      carry_q    <= carry_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = adv1;
  assign out_valid = s2_valid_q;
  assign R         = r_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: a 32-bit/CNT_W=8 instance and an 8-bit/CNT_W=2 instance,
// each checked every cycle against a behavioural model plus literal checks.
module tb_alu_pipe;

  logic clk, rst_n;
  int   checks, failures;

  typedef struct packed {
    logic [31:0] r;
    logic        z, n, c, o;
  } res_t;

  // 32-bit instance signals
  logic        iv32, ir32, ov32, or32, clr32, z32, n32, c32f, o32;
  logic [31:0] a32, b32, r32;
  logic [2:0]  op32;
  logic [7:0]  cnt32;

  // 8-bit instance signals
  logic        iv8, ir8, ov8, or8, clr8, z8, n8, c8f, o8;
  logic [7:0]  a8, b8, r8;
  logic [2:0]  op8;
  logic [1:0]  cnt8;

  alu_pipe u_dut32 (
    .clk(clk), .reset(rst_n), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
    .CTRL(op32), .out_valid(ov32), .out_ready(or32), .R(r32), .zero(z32), .neg(n32),
    .carry(c32f), .ovf(o32), .clr_cnt(clr32), .ovf_cnt(cnt32)
  );

  alu_pipe #(.WIDTH(8), .CNT_W(2)) u_dut8 (
    .clk(clk), .reset(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .CTRL(op8), .out_valid(ov8), .out_ready(or8), .R(r8), .zero(z8), .neg(n8),
    .carry(c8f), .ovf(o8), .clr_cnt(clr8), .ovf_cnt(cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: results straight from the arithmetic definition of each op.
  function automatic res_t model(input longint unsigned a, input longint unsigned b,
                                 input int op, input int w);
    longint unsigned mask, s, r;
    longint          sa, sb;
    bit              as, bs, rs;
    res_t            t;
    mask = (64'd1 << w) - 1;
    a    = a & mask;
    b    = b & mask;
    as   = a[w-1];
    bs   = b[w-1];
    t    = '0;
    r    = 0;
    case (op)
      0: begin s = a + b; r = s & mask; t.c = s[w]; end
      1: begin r = (a - b) & mask; t.c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin
        sa = longint'(a); if (as) sa = sa - (longint'(1) << w);
        sb = longint'(b); if (bs) sb = sb - (longint'(1) << w);
        r  = (sa < sb) ? 1 : 0;
      end
      6: r = (a << (b % w)) & mask;
      default: r = a >> (b % w);
    endcase
    rs = r[w-1];
    if (op == 0) t.o = (as == bs) && (rs != as);
    if (op == 1) t.o = (as != bs) && (rs != as);
    t.r = r[31:0];
    t.z = (r == 0);
    t.n = rs;
    return t;
  endfunction

  res_t q32[$], q8[$];
  int   cnt32_exp, cnt8_exp;

  // Per-cycle compare for the 32-bit instance (inputs are stable at negedge)
  always @(negedge clk) begin
    res_t e;
    bit   hs_ovf;
    hs_ovf = 1'b0;
    if (!rst_n) begin
      q32.delete();
      cnt32_exp = 0;
      chk("rst_valid32", 64'(ov32), 64'd0);
      chk("rst_cnt32", 64'(cnt32), 64'd0);
    end else begin
      chk("cnt32", 64'(cnt32), 64'(cnt32_exp));
      if (ov32) begin
        if (q32.size() == 0) begin
          chk("spurious32", 64'd1, 64'd0);
        end else begin
          e = q32[0];
          chk("out32", 64'({r32, z32, n32, c32f, o32}), 64'(e));
          if (or32) begin
            hs_ovf = e.o;
            void'(q32.pop_front());
          end
        end
      end
      if (clr32) cnt32_exp = 0;
      else if (hs_ovf && cnt32_exp < 255) cnt32_exp++;
      if (iv32 && ir32) q32.push_back(model(64'(a32), 64'(b32), int'(op32), 32));
    end
  end

  // Per-cycle compare for the 8-bit instance
  always @(negedge clk) begin
    res_t e;
    bit   hs_ovf;
    hs_ovf = 1'b0;
    if (!rst_n) begin
      q8.delete();
      cnt8_exp = 0;
      chk("rst_valid8", 64'(ov8), 64'd0);
      chk("rst_cnt8", 64'(cnt8), 64'd0);
    end else begin
      chk("cnt8", 64'(cnt8), 64'(cnt8_exp));
      if (ov8) begin
        if (q8.size() == 0) begin
          chk("spurious8", 64'd1, 64'd0);
        end else begin
          e = q8[0];
          chk("out8", 64'({24'd0, r8, z8, n8, c8f, o8}), 64'(e));
          if (or8) begin
            hs_ovf = e.o;
            void'(q8.pop_front());
          end
        end
      end
      if (clr8) cnt8_exp = 0;
      else if (hs_ovf && cnt8_exp < 3) cnt8_exp++;
      if (iv8 && ir8) q8.push_back(model(64'(a8), 64'(b8), int'(op8), 8));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat; returns with that beat in stage 2 (no stall assumed)
  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    a32 = a; b32 = b; op32 = op; iv32 = 1'b1;
    tick();
    iv32 = 1'b0;
    chk("lat1_32", 64'(ov32), 64'd0);
    tick();
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    a8 = a; b8 = b; op8 = op; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    tick();
  endtask

  logic [31:0] pick[5];

  initial begin
    checks = 0; failures = 0;
    pick[0] = 32'h0; pick[1] = 32'h1; pick[2] = 32'h7FFF_FFFF;
    pick[3] = 32'h8000_0000; pick[4] = 32'hFFFF_FFFF;
    iv32 = 0; or32 = 1; clr32 = 0; a32 = 0; b32 = 0; op32 = 0;
    iv8 = 0; or8 = 1; clr8 = 0; a8 = 0; b8 = 0; op8 = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("reset_state32", 64'({ov32, r32, z32, n32, c32f, o32, cnt32}), 64'd0);
    chk("reset_state8", 64'({ov8, r8, z8, n8, c8f, o8, cnt8}), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("in_ready_after_reset", 64'(ir32), 64'd1);

    // ADD overflow, latency 2
    send32(32'h7FFF_FFFF, 32'h1, 3'd0);
    chk("add_valid", 64'(ov32), 64'd1);
    chk("add_r", 64'(r32), 64'h8000_0000);
    chk("add_flags", 64'({z32, n32, c32f, o32}), 64'b0101);
    tick();
    chk("add_cnt", 64'(cnt32), 64'd1);

    // SUB back-to-back
    a32 = 5; b32 = 5; op32 = 3'd1; iv32 = 1;
    tick();
    a32 = 3; b32 = 5;
    tick();
    iv32 = 0;
    chk("sub_eq", 64'({r32, z32, n32, c32f, o32}), 64'({32'h0, 4'b1000}));
    tick();
    chk("sub_lt", 64'({r32, z32, n32, c32f, o32}), 64'({32'hFFFF_FFFE, 4'b0110}));
    tick();

    // Backpressure: two beats buffered, third held off
    or32 = 0; op32 = 3'd0; iv32 = 1; a32 = 1; b32 = 1;
    tick();
    chk("bp_ready1", 64'(ir32), 64'd1);
    a32 = 2; b32 = 2;
    tick();
    a32 = 3; b32 = 3;
    chk("bp_full", 64'(ir32), 64'd0);
    chk("bp_beat1", 64'({ov32, r32}), 64'({1'b1, 32'd2}));
    tick();
    chk("bp_stable", 64'({ov32, ir32, r32}), 64'({2'b10, 32'd2}));
    or32 = 1;
    #1;
    chk("bp_ready_comb", 64'(ir32), 64'd1);
    tick();
    iv32 = 0;
    chk("bp_beat2", 64'({ov32, r32}), 64'({1'b1, 32'd4}));
    tick();
    chk("bp_beat3", 64'({ov32, r32}), 64'({1'b1, 32'd6}));
    tick();
    chk("bp_empty", 64'(ov32), 64'd0);

    // 8-bit shifts and SLT
    send8(8'h81, 8'h09, 3'd6);
    chk("sll8", 64'(r8), 64'h02);
    send8(8'h80, 8'h07, 3'd7);
    chk("srl8", 64'(r8), 64'h01);
    send8(8'hFF, 8'h01, 3'd5);
    chk("slt8", 64'(r8), 64'h01);
    tick();

    // Saturating 2-bit counter over five overflow results
    chk("cnt8_start", 64'(cnt8), 64'd0);
    a8 = 8'h7F; b8 = 8'h01; op8 = 3'd0; iv8 = 1;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 2) iv8 = 0;
      chk("cnt8_sat", 64'(cnt8), (k == 0) ? 64'd1 : (k == 1) ? 64'd2 : 64'd3);
    end
    send8(8'h7F, 8'h01, 3'd0);
    clr8 = 1;
    tick();
    clr8 = 0;
    chk("cnt8_clr_prio", 64'(cnt8), 64'd0);

    // Reset with two beats in flight
    or32 = 0; op32 = 3'd0; a32 = 32'h7FFF_FFFF; b32 = 1; iv32 = 1;
    tick();
    tick();
    iv32 = 0;
    tick();
    chk("pre_rst_cnt", 64'(cnt32), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(ov32), 64'd0);
    chk("mid_rst_cnt", 64'(cnt32), 64'd0);
    tick();
    rst_n = 1'b1;
    or32 = 1;
    tick();
    send32(32'd10, 32'd20, 3'd0);
    chk("post_rst", 64'({ov32, r32}), 64'({1'b1, 32'd30}));
    tick();

    // Randomised traffic on both instances
    for (int i = 0; i < 600; i++) begin
      iv32  = ($urandom % 4) != 0;
      or32  = ($urandom % 4) != 0;
      clr32 = ($urandom % 40) == 0;
      a32   = ($urandom % 3 == 0) ? pick[$urandom % 5] : $urandom;
      b32   = ($urandom % 3 == 0) ? pick[$urandom % 5] : $urandom;
      op32  = 3'($urandom % 8);
      iv8   = ($urandom % 4) != 0;
      or8   = ($urandom % 3) != 0;
      clr8  = ($urandom % 40) == 0;
      a8    = 8'($urandom);
      b8    = 8'($urandom);
      op8   = 3'($urandom % 8);
      tick();
    end
    iv32 = 0; or32 = 1; clr32 = 0;
    iv8 = 0; or8 = 1; clr8 = 0;
    repeat (4) tick();
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("drain8", 64'(q8.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
